// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block loader: FSM state encoding,
// block size and the byte-count width.
package aes_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_PT,
        S_START,
        S_WAIT
    } state_e;

    // New byte enters at the low end, so the first byte of a block ends up in [127:120].
    function automatic logic [127:0] shift_byte(input logic [127:0] r, input logic [7:0] b);
        return {r[119:0], b};
    endfunction

endpackage

// File: rtl/aes_block_loader.sv
// Byte-stream loader for an AES encryptor: assembles key and plaintext, starts the
// encryptor and waits for done or timeout. Optional KEY_REUSE_EN skips the key load.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         enc_start,
    input  logic         enc_done,
    output logic         blk_done,
    output logic         timeout,
    output logic         busy
`ifdef KEY_REUSE_EN
   ,input  logic         key_reuse
`endif
);

    localparam int                WCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       pt_q, pt_d;
    logic               accept;
`ifdef KEY_REUSE_EN
    logic               key_loaded_q, key_loaded_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            key_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
        end
    end

`ifdef KEY_REUSE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_loaded_q <= 1'b0;
        else      key_loaded_q <= key_loaded_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        key_d     = key_q;
        pt_d      = pt_q;
        in_ready  = 1'b0;
        enc_start = 1'b0;
        blk_done  = 1'b0;
        timeout   = 1'b0;
        accept    = 1'b0;
`ifdef KEY_REUSE_EN
        key_loaded_d = key_loaded_q;
`endif
        case (state_q)
            S_IDLE: begin
                wcnt_d = '0;
                if (in_valid) begin
                    state_d = S_KEY;
`ifdef KEY_REUSE_EN
                    if (key_reuse && key_loaded_q) state_d = S_PT;
`endif
                end
            end
            S_KEY: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    key_d = shift_byte(key_q, in_byte);
                    cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_PT;
`ifdef KEY_REUSE_EN
                        key_loaded_d = 1'b1;
`endif
                    end
                end
            end
            S_PT: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    pt_d  = shift_byte(pt_q, in_byte);
                    cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) state_d = S_START;
                end
            end
            S_START: begin
                enc_start = 1'b1;
                wcnt_d    = WCNT_W'(1);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // done wins over an expiry landing in the same cycle
                if (enc_done) begin
                    blk_done = 1'b1;
                    state_d  = S_IDLE;
                end else if (wcnt_q == WCNT_MAX) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign key       = key_q;
    assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: two instances (TIMEOUT=64 and TIMEOUT=8) share
// the byte stream; a scoreboard holds expected key/plaintext until enc_start.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         enc_done_a, enc_done_b;
    logic         in_ready_a, in_ready_b;
    logic [127:0] key_a, key_b, pt_a, pt_b;
    logic         start_a, start_b, blk_done_a, blk_done_b;
    logic         timeout_a, timeout_b, busy_a, busy_b;
`ifdef KEY_REUSE_EN
    logic         key_reuse;
`endif

    always #5 clk = ~clk;

    aes_block_loader #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready_a),
        .key(key_a), .plaintext(pt_a), .enc_start(start_a), .enc_done(enc_done_a),
        .blk_done(blk_done_a), .timeout(timeout_a), .busy(busy_a)
`ifdef KEY_REUSE_EN
       ,.key_reuse(key_reuse)
`endif
    );

    aes_block_loader #(.TIMEOUT(8)) dut8 (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready_b),
        .key(key_b), .plaintext(pt_b), .enc_start(start_b), .enc_done(enc_done_b),
        .blk_done(blk_done_b), .timeout(timeout_b), .busy(busy_b)
`ifdef KEY_REUSE_EN
       ,.key_reuse(key_reuse)
`endif
    );

    typedef struct packed {
        logic [127:0] k;
        logic [127:0] p;
    } blk_t;

    blk_t         sb[$];
    logic [7:0]   stim[32];
    logic [127:0] cur_key;
    int           errs = 0;
    int           checks = 0;
    int           acc_cnt = 0;

    always @(posedge clk) if (rst && in_valid && in_ready_a) acc_cnt++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // n=32: full key+plaintext; n=16: plaintext only, key retained
    function automatic void push_exp(input int n);
        blk_t e;
        e.k = (n == 32) ? '0 : cur_key;
        e.p = '0;
        for (int i = 0; i < n; i++) begin
            if (n == 32 && i < 16) e.k = {e.k[119:0], stim[i]};
            else                   e.p = {e.p[119:0], stim[i]};
        end
        cur_key = e.k;
        sb.push_back(e);
    endfunction

    task automatic stream(input int n, input bit gap);
        int  i = 0;
        int  cyc = 0;
        int  acc0 = acc_cnt;
        bit  ph = 1'b0;
        bit  early = 1'b0;
        while (i < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (start_a || start_b) early = 1'b1;
            if (gap && ph) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_byte  = stim[i];
                if (in_ready_a) i++;
            end
            ph = ~ph;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_bound", i, n);
        chk("no_early_start", early, 1'b0);
        chk("accept_count", acc_cnt - acc0, n);
    endtask

    // Called at the negedge right after the last accept: the START cycle.
    task automatic check_start();
        blk_t e;
        chk("enc_start_a", start_a, 1'b1);
        chk("enc_start_b", start_b, 1'b1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk("key_a", key_a, e.k);
            chk("pt_a", pt_a, e.p);
            chk("key_b", key_b, e.k);
            chk("pt_b", pt_b, e.p);
        end
    endtask

    // da/db: WAIT cycle on which enc_done is raised (0 = never) for each instance
    task automatic wait_phase(input int da, input int db);
        int tb_end = (db >= 1 && db <= 8) ? db : 8;
        int last = ((da > tb_end) ? da : tb_end) + 1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            enc_done_a = (k == da);
            enc_done_b = (k == db);
            #1;
            chk("busy_a", busy_a, k <= da);
            chk("blk_done_a", blk_done_a, k == da);
            chk("timeout_a", timeout_a, 1'b0);
            chk("start_a_low", start_a, 1'b0);
            chk("busy_b", busy_b, k <= tb_end);
            chk("blk_done_b", blk_done_b, (k == db) && (db <= 8));
            chk("timeout_b", timeout_b, (k == 8) && (tb_end == 8) && (db != 8));
        end
        enc_done_a = 1'b0;
        enc_done_b = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_byte = '0; in_valid = 1'b0;
        enc_done_a = 1'b0; enc_done_b = 1'b0; cur_key = '0;
`ifdef KEY_REUSE_EN
        key_reuse = 1'b0;
`endif
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_in_ready", in_ready_a, 1'b0);
        chk("rst_key", key_a, '0);
        chk("rst_pt", pt_a, '0);
        chk("rst_outs", {start_a, blk_done_a, timeout_a, busy_b}, 4'b0);
        in_valid = 1'b0;
        rst = 1'b1;

        // Known-answer block, done on WAIT cycle 12; TIMEOUT=8 instance expires
        for (int i = 0; i < 32; i++) stim[i] = (i < 16) ? 8'(i) : 8'((i - 16) * 8'h11);
        push_exp(32);
        stream(32, 1'b0);
        check_start();
        chk("kat_key", key_a, 128'h000102030405060708090a0b0c0d0e0f);
        chk("kat_pt", pt_a, 128'h00112233445566778899aabbccddeeff);
        wait_phase(12, 0);

        // Gapped valid; done and expiry coincide on the TIMEOUT=8 instance
        push_exp(32);
        stream(32, 1'b1);
        check_start();
        wait_phase(3, 8);

        // Reset after 7 key bytes, then a fresh block
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom_range(255));
        stream(7, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_key", key_a, '0);
        chk("abort_ready", in_ready_a, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom_range(255));
        push_exp(32);
        stream(32, 1'b0);
        check_start();
        wait_phase(5, 10);

`ifdef KEY_REUSE_EN
        for (int i = 0; i < 16; i++) stim[i] = 8'($urandom_range(255));
        push_exp(16);
        key_reuse = 1'b1;
        stream(16, 1'b0);
        key_reuse = 1'b0;
        check_start();
        wait_phase(2, 1);
`endif

        // Reset mid-wait; a late enc_done must be ignored
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom_range(255));
        push_exp(32);
        stream(32, 1'b0);
        check_start();
        repeat (3) @(negedge clk);
        chk("mid_wait_busy", busy_a, 1'b1);
        rst = 1'b0;
        #1;
        chk("wait_abort_busy", busy_a, 1'b0);
        chk("wait_abort_pt", pt_a, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        enc_done_a = 1'b1;
        enc_done_b = 1'b1;
        #1;
        chk("late_done_a", blk_done_a, 1'b0);
        chk("late_done_b", blk_done_b, 1'b0);
        @(negedge clk);
        enc_done_a = 1'b0;
        enc_done_b = 1'b0;
        chk("late_done_idle", {busy_a, busy_b}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum cycles spent waiting for enc_done, legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_byte, input, 8 bits: byte stream carrying key and plaintext bytes.
REQ-005 SHALL have port in_valid, input, 1 bit: in_byte holds a valid byte.
REQ-006 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-007 SHALL have port key, output, 128 bits: assembled key, driven to the encryptor.
REQ-008 SHALL have port plaintext, output, 128 bits: assembled plaintext block, driven to the encryptor.
REQ-009 SHALL have port enc_start, output, 1 bit: one-cycle start pulse to the encryptor.
REQ-010 SHALL have port enc_done, input, 1 bit: encryptor reports that ciphertext is ready.
REQ-011 SHALL have port blk_done, output, 1 bit: one-cycle pulse when the block completes.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse when enc_done is not seen within TIMEOUT cycles.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, KEY, PT, START and WAIT.
REQ-015 SHALL, in IDLE with in_valid high, go to KEY on the next edge; in_ready SHALL be low in IDLE.
REQ-016 SHALL drive in_ready high only in KEY and PT; a byte is accepted when in_valid and in_ready are both high.
REQ-017 SHALL shift each accepted byte into the low end of the register for the current state (key in KEY, plaintext in PT), so the first byte lands in bits [127:120].
REQ-018 SHALL count accepted bytes with a 4-bit counter; the 16th accept (count 15) SHALL wrap the count to 0 and move KEY to PT, or PT to START.
REQ-019 SHALL hold the count and register contents during cycles with in_valid low.
REQ-020 SHALL drive enc_start high for exactly the single START cycle, then go to WAIT.
REQ-021 SHALL keep key and plaintext stable from START until the next byte is accepted.
REQ-022 SHALL, in WAIT, count cycles from 1; enc_done high SHALL pulse blk_done and return to IDLE.
REQ-023 SHALL, when the count reaches TIMEOUT without enc_done, pulse timeout and return to IDLE.
REQ-024 SHALL give enc_done priority over timeout when both occur in the same cycle; only blk_done pulses.
REQ-025 SHALL ignore enc_done outside WAIT.
REQ-026 SHALL size the WAIT counter at $clog2(TIMEOUT+1) bits; the counter SHALL saturate and never wrap.

Reset
REQ-027 SHALL, while rst is low, immediately force: state IDLE; byte count, wait counter, key and plaintext to 0; in_ready, enc_start, blk_done, timeout and busy to 0.
REQ-028 SHALL treat reset mid-load or mid-wait as an abort: partial bytes are discarded, and a late enc_done after release is ignored.

Configuration
REQ-029 SHALL, with KEY_REUSE_EN defined, add input port key_reuse (1 bit) and an internal key_loaded flag; key_loaded is set on completing KEY and cleared by reset.
REQ-030 SHALL, with KEY_REUSE_EN defined, go IDLE to PT when key_reuse and key_loaded are both high at the IDLE exit, and keep key unchanged.
REQ-031 SHALL, without KEY_REUSE_EN, have no key_reuse port and always load 16 key bytes before plaintext.

Structure
REQ-032 SHALL take the state enum type, the constant BLOCK_BYTES=16 and the byte-count width from shared package aes_pkg.
REQ-033 SHALL be a single module with no sub-modules; it feeds encryptor ports key, plaintext and start, and takes done from the encryptor.

Verification
REQ-034 SHALL cover: stream key bytes 00..0f, then plaintext bytes 00,11,..,ff -> key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff, one enc_start pulse; enc_done 12 cycles later -> one blk_done pulse.
REQ-035 SHALL cover: in_valid low every other cycle during loading -> same key/plaintext values; 32 accepts; enc_start 1 cycle after the last accept.
REQ-036 SHALL cover: TIMEOUT=8, enc_done never asserted -> timeout pulse on the 8th WAIT cycle, busy low on the following cycle.
REQ-037 SHALL cover: rst low after 7 key bytes, then a fresh 32-byte load -> only the post-reset bytes appear; no enc_start before the 32nd new byte.
REQ-038 SHALL cover: with KEY_REUSE_EN, second block loaded with key_reuse=1 and 16 bytes -> key unchanged, plaintext updated, enc_start after the 16th byte.
REQ-039 SHALL cover: enc_done and the TIMEOUT expiry in the same cycle -> blk_done=1 and timeout=0.
